// File: rtl/l1_abs_accum.sv
// rtl/l1_abs_accum.sv - Absolute-difference accumulator emitting the negated L1 distance
// Sums |diff| over KLEN accepted samples; the result register doubles as a one-deep output skid.
module l1_abs_accum #(
    parameter int NBIT = 8,
    parameter int KLEN = 9,
    parameter int ACCW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBIT-1:0] i_diff,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_clr,
    output logic [ACCW-1:0] o_sum,
    output logic            o_valid,
    input  logic            i_ready
);
    localparam int CW = (KLEN > 1) ? $clog2(KLEN) : 1;

    logic [CW-1:0]   r_count;
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] r_sum;
    logic            r_valid;

    logic [NBIT-1:0] w_mag;
    logic [ACCW-1:0] w_mag_ext;
    logic [ACCW-1:0] w_total;
    logic            w_ready;
    logic            w_accept;
    logic            w_consume;
    logic            w_complete;

    // Unsigned negation so that the most negative code maps to its true magnitude.
    assign w_mag      = i_diff[NBIT-1] ? (~i_diff + NBIT'(1)) : i_diff;
    assign w_mag_ext  = {{(ACCW-NBIT){1'b0}}, w_mag};
    assign w_total    = r_acc + w_mag_ext;

    assign w_ready    = !r_valid || i_ready;
    assign w_accept   = i_valid && w_ready;
    assign w_consume  = r_valid && i_ready;
    assign w_complete = w_accept && !i_clr && (r_count == CW'(KLEN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (i_clr) begin
            // A sample arriving alongside the flush opens the new window.
            r_count <= w_accept ? CW'(1) : '0;
            r_acc   <= w_accept ? w_mag_ext : '0;
        end else if (w_complete) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CW'(1);
            r_acc   <= w_total;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_sum   <= ACCW'(0) - w_total;
            r_valid <= 1'b1;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_sum   = r_sum;
    assign o_valid = r_valid;
endmodule
